regfile_sweep: RTL and testbench
================================

// Module: regfile_sweep
// PURPOSE
//   Parametrised general-purpose register file for the single-cycle/pipelined CPU datapath.
//   Two combinational read ports (rs, rt), one synchronous write port (rd).
//   Optional hardwired-zero entry 0 and optional write-to-read bypass.
//   Clearing is done by a sequential sweep FSM, one entry per cycle, on reset or on request.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary
//   BYPASS    1   1: same-cycle write data forwarded to matching read port; 0: no forwarding
// PORTS
//   clk_i        in   1       clock; all state updates on rising edge
//   rst_i        in   1       synchronous, active-high reset
//   clr_i        in   1       request a full clear sweep (sampled in IDLE only)
//   rs_addr_i    in   ADDR_W  read port A address
//   rt_addr_i    in   ADDR_W  read port B address
//   rd_addr_i    in   ADDR_W  write address
//   rd_data_i    in   DATA_W  write data
//   reg_write_i  in   1       write enable
//   rs_data_o    out  DATA_W  read port A data (combinational)
//   rt_data_o    out  DATA_W  read port B data (combinational)
//   busy_o       out  1       1 while clear sweep is in progress
// BEHAVIOUR
//   FSM states: CLEAR, IDLE. Sweep pointer ptr is ADDR_W bits.
//   rst_i=1 at an edge: state<=CLEAR, ptr<=0, mem[0]<=0; repeats every edge rst_i is held.
//   CLEAR, rst_i=0: mem[ptr]<=0, ptr<=ptr+1; at ptr==DEPTH-1 state<=IDLE, ptr<=0.
//   So busy_o falls after exactly DEPTH edges with rst_i low (32 for ADDR_W=5).
//   Reset mid-sweep: ptr restarts at 0; sweep is never resumed partially.
//   IDLE, clr_i=1: state<=CLEAR, ptr<=0 at that edge; any write in that cycle is dropped.
//   clr_i while in CLEAR is ignored (sweep continues, not restarted).
//   busy_o = (state==CLEAR); combinational from state, 1 from the first reset edge.
//   Write: in IDLE, clr_i=0, reg_write_i=1 -> mem[rd_addr_i]<=rd_data_i at edge;
//     suppressed when ZERO_REG=1 and rd_addr_i==0. All writes ignored during CLEAR.
//   Read: rs_data_o = 0 if busy_o, or ZERO_REG=1 and rs_addr_i==0;
//     else rd_data_i if BYPASS=1, reg_write_i=1, clr_i=0, rd_addr_i==rs_addr_i;
//     else mem[rs_addr_i]. rt_data_o identical with rt_addr_i.
//   While busy_o=1 both read ports return 0 regardless of memory contents.
//   Both read ports may address the same entry, or the write entry, simultaneously.
//   No latency on reads; write visible on mem read path the cycle after the edge.
//   Power-up before first reset: contents and state undefined; reset is mandatory.
//   No arithmetic beyond ptr increment; ptr never wraps past DEPTH-1 (FSM exits first).
// TESTING  (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1 unless stated)
//   Reset 1 cycle, release -> busy_o=1 for 32 edges, then 0; all 32 entries read 0.
//   IDLE: write r5=0xDEADBEEF; next cycle rs=5,rt=5 -> both 0xDEADBEEF.
//   Write r0=0x1234 -> rs=0 reads 0x0000_0000; same-cycle bypass on r0 also yields 0.
//   r7=0x11; same cycle write r7=0x22 with rs=7 -> rs_data_o=0x22 (BYPASS=1), 0x11 (BYPASS=0).
//   Fill r1..r31=index; assert clr_i with write r3=0x99 -> write dropped, busy 32 cycles, all read 0.
//   Reset asserted at sweep cycle 10 of 32 -> busy_o stays 1; 32 further edges after release.

Source files
------------

// File: rtl/regfile_sweep.sv
// Register file with two combinational read ports and one write port; zero-latency reads, writes land at the edge.
// A clear sweep zeroes one entry per cycle after reset or clr_i; no backpressure, busy_o flags the sweep.
module regfile_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               fwd_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The sweep and the normal write port share one memory write path.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = rd_addr_i;
        wr_data = rd_data_i;
        if (rst_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = '0;
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_d = ST_CLEAR;
                        ptr_d   = '0;
                    end else if (reg_write_i && !((ZERO_REG != 0) && (rd_addr_i == '0))) begin
                        wr_en = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy_o = (state_q == ST_CLEAR);
    assign fwd_en = (BYPASS != 0) && reg_write_i && !clr_i;

    always_comb begin
        rs_data_o = mem_q[rs_addr_i];
        rt_data_o = mem_q[rt_addr_i];
        if (fwd_en && (rd_addr_i == rs_addr_i)) begin
            rs_data_o = rd_data_i;
        end
        if (fwd_en && (rd_addr_i == rt_addr_i)) begin
            rt_data_o = rd_data_i;
        end
        if (busy_o || ((ZERO_REG != 0) && (rs_addr_i == '0))) begin
            rs_data_o = '0;
        end
        if (busy_o || ((ZERO_REG != 0) && (rt_addr_i == '0))) begin
            rt_data_o = '0;
        end
    end

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep: a bypassing and a non-bypassing instance share all inputs.
// Stimulus pushes expected read/busy values; a negedge monitor pops and compares them.
module tb_regfile_sweep;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        reg_write_i;

    logic [31:0] rs_data_o, rt_data_o, nb_rs_data_o, nb_rt_data_o;
    logic        busy_o, nb_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    string       name_q[$];
    logic [31:0] exp_rs_q[$];
    logic [31:0] exp_rt_q[$];
    logic [31:0] exp_nb_q[$];
    logic        exp_busy_q[$];

    always #5 clk_i = ~clk_i;

    regfile_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .reg_write_i(reg_write_i),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .busy_o(busy_o)
    );

    regfile_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .reg_write_i(reg_write_i),
        .rs_data_o(nb_rs_data_o), .rt_data_o(nb_rt_data_o), .busy_o(nb_busy_o)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endfunction

    // Monitor: compares every entry queued for the current cycle.
    always @(negedge clk_i) begin
        while (name_q.size() > 0) begin
            string       nm;
            logic [31:0] e_rs, e_rt, e_nb;
            logic        e_busy;
            nm     = name_q.pop_front();
            e_rs   = exp_rs_q.pop_front();
            e_rt   = exp_rt_q.pop_front();
            e_nb   = exp_nb_q.pop_front();
            e_busy = exp_busy_q.pop_front();
            chk({nm, ".rs"}, rs_data_o, e_rs);
            chk({nm, ".rt"}, rt_data_o, e_rt);
            chk({nm, ".busy"}, {31'd0, busy_o}, {31'd0, e_busy});
            chk({nm, ".nb_rs"}, nb_rs_data_o, e_nb);
            chk({nm, ".nb_busy"}, {31'd0, nb_busy_o}, {31'd0, e_busy});
        end
    end

    task automatic expect_out(input string nm, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] nb, input logic busy);
        name_q.push_back(nm);
        exp_rs_q.push_back(rs);
        exp_rt_q.push_back(rt);
        exp_nb_q.push_back(nb);
        exp_busy_q.push_back(busy);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sweep_check(input string nm);
        for (int i = 0; i < 32; i++) begin
            rs_addr_i = 5'(i);
            rt_addr_i = 5'(31 - i);
            expect_out($sformatf("%s_busy%0d", nm, i), 32'd0, 32'd0, 32'd0, 1'b1);
            step();
        end
        expect_out({nm, "_done"}, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            rs_addr_i = 5'(i);
            rt_addr_i = 5'(31 - i);
            expect_out($sformatf("%s_r%0d", nm, i), 32'd0, 32'd0, 32'd0, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; reg_write_i = 1'b0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0; rd_data_i = '0;
        step();
        rst_i = 1'b0;
        sweep_check("rst");
        step();
        read_all_zero("post_rst");

        // Write r5, bypass visible in the write cycle only on the bypassing instance.
        reg_write_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF;
        rs_addr_i = 5'd5; rt_addr_i = 5'd6;
        expect_out("wr5_fwd", 32'hDEADBEEF, 32'd0, 32'd0, 1'b0);
        step();
        reg_write_i = 1'b0; rt_addr_i = 5'd5;
        expect_out("rd5", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        step();

        // r0 is hardwired to zero, including its bypass path.
        reg_write_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h1234;
        rs_addr_i = 5'd0; rt_addr_i = 5'd0;
        expect_out("wr0_fwd", 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        reg_write_i = 1'b0;
        expect_out("rd0", 32'd0, 32'd0, 32'd0, 1'b0);
        step();

        // Overwrite r7 while reading it.
        reg_write_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h11;
        step();
        rd_data_i = 32'h22; rs_addr_i = 5'd7; rt_addr_i = 5'd7;
        expect_out("r7_fwd", 32'h22, 32'h22, 32'h11, 1'b0);
        step();
        reg_write_i = 1'b0;
        expect_out("r7_after", 32'h22, 32'h22, 32'h22, 1'b0);
        step();

        // Fill r1..r31 with their index and read back.
        for (int i = 1; i < 32; i++) begin
            reg_write_i = 1'b1; rd_addr_i = 5'(i); rd_data_i = 32'(i);
            step();
        end
        reg_write_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr_i = 5'(i);
            rt_addr_i = 5'(31 - i);
            expect_out($sformatf("fill_r%0d", i), 32'(i), 32'(31 - i), 32'(i), 1'b0);
            step();
        end

        // Clear request with a simultaneous write: write is dropped and not forwarded.
        clr_i = 1'b1; reg_write_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h99;
        rs_addr_i = 5'd3; rt_addr_i = 5'd4;
        expect_out("clr_req", 32'd3, 32'd4, 32'd3, 1'b0);
        step();
        clr_i = 1'b0;
        rd_addr_i = 5'd9; rd_data_i = 32'h55;
        for (int i = 0; i < 32; i++) begin
            clr_i = (i == 5);
            rs_addr_i = 5'd9;
            rt_addr_i = 5'd3;
            expect_out($sformatf("clr_busy%0d", i), 32'd0, 32'd0, 32'd0, 1'b1);
            step();
        end
        clr_i = 1'b0; reg_write_i = 1'b0;
        expect_out("clr_done", 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        read_all_zero("post_clr");

        // Reset in the middle of a sweep restarts it from entry 0.
        reg_write_i = 1'b1; rd_addr_i = 5'd10; rd_data_i = 32'hAA;
        step();
        reg_write_i = 1'b0; rs_addr_i = 5'd10; rt_addr_i = 5'd10;
        expect_out("r10", 32'hAA, 32'hAA, 32'hAA, 1'b0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        rst_i = 1'b1;
        expect_out("mid_rst", 32'd0, 32'd0, 32'd0, 1'b1);
        step();
        rst_i = 1'b0;
        sweep_check("mid");
        step();
        rs_addr_i = 5'd10; rt_addr_i = 5'd31;
        expect_out("mid_r10", 32'd0, 32'd0, 32'd0, 1'b0);
        step();

        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
